// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_ctrl_pkg -- shared encodings for the pipeline sequencer
// Revision: 1.0
// ------------------------------------------------------------------
package pipe_ctrl_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_INIT     = 2'd0;
  localparam state_t ST_RUN      = 2'd1;
  localparam state_t ST_MEM_WAIT = 2'd2;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0;
endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ------------------------------------------------------------------
// hazard_detect -- combinational load-use compare between ID and EX
// Revision: 1.0
// ------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wreg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       hazard
);
  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_use_rs && (id_rs == ex_wreg);
    rt_match = id_use_rt && (id_rt == ex_wreg);
    // $0 is hardwired zero, so a load targeting it creates no dependency
    hazard   = ex_mem_read && (ex_wreg != REG_ZERO) && (rs_match || rt_match);
  end
endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_ctrl -- 5-stage pipeline sequencer: stalls, flushes, purge, counters
// Revision: 1.0
// ------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYC = 4,
  parameter int MEM_TMO  = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  state_t             state_q,     state_d;
  logic [INIT_W-1:0]  init_ctr_q,  init_ctr_d;
  logic [7:0]         tmo_ctr_q,   tmo_ctr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic run_rules;
  logic mem_stall;
  logic wait_hold;
  logic timeout;
  logic freeze;
  logic redir;
  logic load_use;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_wreg     (ex_wreg),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .hazard      (hazard)
  );

  // Event classification in priority order: memory wait > redirect > load-use
  always_comb begin
    run_rules = (state_q == ST_RUN) || ((state_q == ST_MEM_WAIT) && mem_ready);
    mem_stall = (state_q == ST_RUN) && mem_req && !mem_ready;
    wait_hold = (state_q == ST_MEM_WAIT) && !mem_ready;
    timeout   = wait_hold && (tmo_ctr_q == 8'(MEM_TMO));
    freeze    = mem_stall || wait_hold;
    redir     = run_rules && !mem_stall && ex_redirect;
    load_use  = run_rules && !mem_stall && !ex_redirect && hazard;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_ctr_q  <= '0;
      tmo_ctr_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_ctr_q  <= init_ctr_d;
      tmo_ctr_q   <= tmo_ctr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_ctr_d  = init_ctr_q;
    tmo_ctr_d   = tmo_ctr_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_ctr_q == INIT_W'(INIT_CYC - 1)) begin
          state_d    = ST_RUN;
          init_ctr_d = '0;
        end else begin
          init_ctr_d = init_ctr_q + INIT_W'(1);
        end
      end
      ST_RUN: begin
        if (mem_stall) begin
          state_d   = ST_MEM_WAIT;
          tmo_ctr_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready || timeout) begin
          state_d   = ST_RUN;
          tmo_ctr_d = '0;
        end else begin
          tmo_ctr_d = tmo_ctr_q + 8'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if ((freeze || load_use) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redir && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_comb begin
    pc_en        = 1'b1;
    pc_redirect  = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    mem_err      = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_q == ST_INIT) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      // Abort: let EX/MEM take the bubble so the stuck access is dropped
      if (timeout) begin
        mem_err     = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
      end
    end else if (redir) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl
// Revision: 1.0
// ------------------------------------------------------------------
module tb_pipe_ctrl;
  localparam int CNT_W = 4;

  // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_err}
  localparam logic [8:0] O_RST    = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] O_INIT   = 9'b0_0_1_1_1_1_1_1_0;
  localparam logic [8:0] O_RUN    = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] O_LU     = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] O_REDIR  = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] O_FREEZE = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] O_TMO    = 9'b0_0_0_0_0_1_1_1_1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic id_use_rs, id_use_rt, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] outs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.INIT_CYC(4), .MEM_TMO(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_wreg(ex_wreg), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, mem_wb_flush, mem_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [8:0] exp);
    #1;
    chk(tag, {23'd0, outs}, {23'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush);
    chk({tag, "_stall"}, {28'd0, stall_cnt}, exp_stall);
    chk({tag, "_flush"}, {28'd0, flush_cnt}, exp_flush);
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_mem_read = 1'b0; ex_wreg = 5'd0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // EX = LW $5, ID = ADD $6,$5,$7
  task automatic set_hazard();
    ex_mem_read = 1'b1; ex_wreg = 5'd5;
    id_rs = 5'd5; id_rt = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b1;
  endtask

  initial begin
    // T1: reset and post-reset purge
    rst = 1'b1;
    idle_inputs();
    chk_outs("rst_outs", O_RST);
    chk_cnt("rst", 0, 0);
    tick(); tick();
    chk_outs("rst_held", O_RST);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_outs($sformatf("init_%0d", i), O_INIT);
      tick();
    end
    chk_outs("run_default", O_RUN);
    tick();

    // T2: load-use via rs
    set_hazard();
    chk_outs("lu_rs", O_LU);
    tick();
    chk_cnt("lu_rs", 1, 0);
    ex_mem_read = 1'b0;
    chk_outs("lu_after", O_RUN);
    tick();
    // load to $0 never stalls
    ex_mem_read = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0;
    chk_outs("lu_reg0", O_RUN);
    tick();
    chk_cnt("lu_reg0", 1, 0);
    // load-use via rt, then the same register with use_rt cleared
    ex_wreg = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
    chk_outs("lu_rt", O_LU);
    tick();
    chk_cnt("lu_rt", 2, 0);
    id_use_rt = 1'b0;
    chk_outs("lu_rt_unused", O_RUN);
    tick();

    // T3: redirect overrides a concurrent hazard
    set_hazard();
    ex_redirect = 1'b1;
    chk_outs("redir_hz", O_REDIR);
    tick();
    chk_cnt("redir_hz", 2, 1);
    idle_inputs();
    chk_outs("redir_after", O_RUN);
    tick();

    // T4: 3-cycle memory wait masks redirect and hazard, redirect applied on release
    set_hazard();
    ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_outs($sformatf("wait_%0d", i), O_FREEZE);
      tick();
    end
    chk_cnt("wait3", 5, 1);
    mem_ready = 1'b1;
    chk_outs("wait_release", O_REDIR);
    tick();
    chk_cnt("wait_release", 5, 2);
    idle_inputs();
    chk_outs("wait_after", O_RUN);
    tick();

    // T5: timeout with MEM_TMO=8: entry cycle plus 8 waiting cycles, abort on the last
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk_outs($sformatf("tmo_%0d", i), (i == 8) ? O_TMO : O_FREEZE);
      tick();
    end
    mem_req = 1'b0;
    chk_outs("tmo_after", O_RUN);
    chk_cnt("tmo", 14, 2);
    tick();

    // T5b: reset in the middle of a wait
    mem_req = 1'b1; mem_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    chk_outs("rst_mid_wait", O_RST);
    chk_cnt("rst_mid_wait", 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_no_err", {31'd0, mem_err}, 32'd0);
    end
    rst = 1'b0;
    mem_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_outs($sformatf("reinit_%0d", i), O_INIT);
      tick();
    end
    chk_outs("rerun", O_RUN);
    tick();

    // T6: counter saturation with CNT_W=4
    set_hazard();
    for (int i = 0; i < 20; i++) begin
      chk_outs($sformatf("sat_lu_%0d", i), O_LU);
      tick();
      chk($sformatf("sat_cnt_%0d", i), {28'd0, stall_cnt}, (i + 1 > 15) ? 15 : i + 1);
    end
    idle_inputs();
    chk_outs("final_run", O_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
